// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: streams words from a combinational instruction memory
// into a small FIFO and hands them to the core with a valid/ready handshake and tagged PC.
module fetch_prefetch_buffer #(
    parameter int          ADDR_W    = 6,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [ADDR_W-1:0]        imem_reg,
    input  logic [31:0]              imem_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C  = DEPTH[PTR_W:0];
    localparam logic [ADDR_W-1:0] RESET_IDX = RESET_PC[ADDR_W+1:2];

    logic [ADDR_W-1:0] fetch_idx;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] idx_mem  [DEPTH];

    logic pop;
    logic push;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    // Redirect suppresses the push; a full FIFO may still push when the head leaves this cycle.
    assign push        = !redirect & ((count < DEPTH_C) | pop);

    assign imem_reg    = fetch_idx;
    assign fifo_count  = count;

    // Head outputs are masked while empty so stale or never-written entries never escape.
    assign instr_data  = instr_valid ? data_mem[rd_ptr] : NOP_INSTR;
    assign instr_pc    = instr_valid ? {{(30-ADDR_W){1'b0}}, idx_mem[rd_ptr], 2'b00} : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_idx <= RESET_IDX;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (redirect) begin
            fetch_idx <= redirect_pc[ADDR_W+1:2];
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                fetch_idx <= fetch_idx + 1'b1;
                wr_ptr    <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy tracking guarantees an entry is
    // written before it is ever presented, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_data;
            idx_mem[wr_ptr]  <= fetch_idx;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: vector table for fill/stream/redirect/wrap,
// plus hand sequences for asynchronous mid-stream reset and continuous-ready streaming.
module tb_fetch_prefetch_buffer;

    localparam logic [31:0] W0  = 32'h1000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  imem_reg;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word i holds 0x1000_0000 + i.
    assign imem_data = W0 + {26'h0, imem_reg};

    fetch_prefetch_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_reg    (imem_reg),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        valid;
        logic [31:0] data;
        logic [31:0] pc;
        logic [2:0]  count;
        logic [5:0]  imem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic rdy,
                                input logic vl, input logic [31:0] pc, input int cnt,
                                input int im);
        vec_t v;
        v.rd    = rd;
        v.rpc   = rpc;
        v.rdy   = rdy;
        v.valid = vl;
        v.pc    = vl ? pc : 32'h0;
        v.data  = vl ? (W0 + (pc >> 2)) : NOP;
        v.count = cnt[2:0];
        v.imem  = im[5:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic vl, input logic [31:0] data,
                             input logic [31:0] pc, input logic [2:0] cnt, input logic [5:0] im);
        check({tag, " valid"}, {31'h0, instr_valid}, {31'h0, vl});
        check({tag, " data"},  instr_data, data);
        check({tag, " pc"},    instr_pc, pc);
        check({tag, " count"}, {29'h0, fifo_count}, {29'h0, cnt});
        check({tag, " imem"},  {26'h0, imem_reg}, {26'h0, im});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill with ready low, stall, ready toggling while full.
        vecs.push_back(mk(0, 0, 0, 1, 32'h00, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00, 2, 2));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00, 3, 3));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00, 4, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h00, 4, 4));
        vecs.push_back(mk(0, 0, 1, 1, 32'h04, 4, 5));
        vecs.push_back(mk(0, 0, 0, 1, 32'h04, 4, 5));
        vecs.push_back(mk(0, 0, 1, 1, 32'h08, 4, 6));
        vecs.push_back(mk(0, 0, 1, 1, 32'h0C, 4, 7));
        vecs.push_back(mk(0, 0, 1, 1, 32'h10, 4, 8));
        // Redirect to 0x80 while streaming.
        vecs.push_back(mk(1, 32'h80, 1, 0, 0, 0, 32));
        vecs.push_back(mk(0, 0, 1, 1, 32'h80, 1, 33));
        vecs.push_back(mk(0, 0, 1, 1, 32'h84, 1, 34));
        // Redirect to 0xF8: index wraps 63 -> 0.
        vecs.push_back(mk(1, 32'hF8, 1, 0, 0, 0, 62));
        vecs.push_back(mk(0, 0, 1, 1, 32'hF8, 1, 63));
        vecs.push_back(mk(0, 0, 1, 1, 32'hFC, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h00, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 32'h04, 1, 2));
        // Back-to-back redirects; second target has high and alignment bits set (0x1A3 -> idx 40).
        vecs.push_back(mk(1, 32'h40, 1, 0, 0, 0, 16));
        vecs.push_back(mk(1, 32'h1A3, 0, 0, 0, 0, 40));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA0, 1, 41));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA0, 2, 42));
        vecs.push_back(mk(0, 0, 0, 1, 32'hA0, 3, 43));

        reset_n     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check_all("reset", 1'b0, NOP, 32'h0, 3'd0, 6'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            instr_ready = vecs[i].rdy;
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].valid, vecs[i].data, vecs[i].pc,
                      vecs[i].count, vecs[i].imem);
        end

        // Asynchronous reset with three entries held: outputs must clear before the next edge.
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, NOP, 32'h0, 3'd0, 6'd0);
        repeat (2) @(negedge clk);
        check_all("rst_hold", 1'b0, NOP, 32'h0, 3'd0, 6'd0);
        reset_n     = 1'b1;
        instr_ready = 1'b1;

        // Continuous ready from reset: one instruction per cycle, count stays 1.
        @(posedge clk);
        @(negedge clk);
        check_all("stream0", 1'b1, W0, 32'h0, 3'd1, 6'd1);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("stream%0d", k), 1'b1, W0 + k, 32'(k * 4), 3'd1, 6'(k + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
